rom_addr_sequencer: RTL and testbench
=====================================

// Module: rom_addr_sequencer
// PURPOSE
//  Address sequencer sitting directly upstream of the 16x4 lookup ROM (reg_16x4).
//  - Drives the ROM Address bus and samples the ROM's combinational data output.
//  - Streams each sampled word downstream over a valid/ready handshake.
//  - On Start: one up/down pass over [START_ADDR..END_ADDR], or continuous wrap.
// PARAMETERS
//  ADDR_W      4   ROM address width
//  DATA_W      4   ROM data width
//  START_ADDR  0   first address of a pass (inclusive)
//  END_ADDR    15  last address of a pass (inclusive); START_ADDR <= END_ADDR
// PORTS
//  Clk        in   1       single clock, rising edge
//  Rst        in   1       synchronous, active-high reset
//  Start      in   1       begin a pass; sampled only in IDLE
//  Dir        in   1       0 = ascending, 1 = descending; latched with Start
//  Loop       in   1       1 = wrap and continue; latched with Start
//  Stop       in   1       request end of run after the current word handshakes
//  Address    out  ADDR_W  to ROM Address
//  Rom_Data   in   DATA_W  from ROM Y
//  Out_Data   out  DATA_W  registered ROM word
//  Out_Addr   out  ADDR_W  address that produced Out_Data
//  Out_Valid  out  1       Out_Data/Out_Addr valid
//  Out_Ready  in   1       downstream accepts when Out_Valid & Out_Ready
//  Busy       out  1       high in any state except IDLE
//  Done       out  1       one-cycle pulse when a run ends
//  Checksum   out  8       running sum of emitted words (see CONFIGURATION)
// BEHAVIOUR
//  Reset (Rst=1 at posedge, any state, mid-run included):
//   - state=IDLE; Address=START_ADDR; Out_Data=0; Out_Addr=0.
//   - Out_Valid=0; Busy=0; Done=0; Checksum=0; latched Dir/Loop/Stop=0.
//  States: IDLE, FETCH, HOLD, DONE.
//  IDLE
//   - Start=1 -> latch Dir, Loop; clear Stop latch.
//   - Address = START_ADDR (Dir=0) or END_ADDR (Dir=1); go FETCH.
//   - Start outside IDLE is ignored.
//  FETCH (1 cycle)
//   - Out_Data<=Rom_Data, Out_Addr<=Address, Out_Valid<=1; go HOLD.
//   - ROM is combinational: data is sampled in the same cycle Address is stable.
//  HOLD
//   - Out_Valid, Out_Data and Out_Addr are held stable until handshake.
//   - On handshake: Out_Valid<=0 and Checksum updates in the same edge.
//   - If Stop latch set: go DONE.
//   - Else if Address is last (END_ADDR ascending / START_ADDR descending):
//     Loop=1 -> Address wraps to first; go FETCH. Loop=0 -> go DONE.
//   - Else Address +1 (Dir=0) or -1 (Dir=1); go FETCH.
//  DONE (1 cycle)
//   - Done=1; go IDLE. Address keeps its last value.
//  Stop
//   - Latched on any cycle while Busy; cleared on entry to a new run.
//   - Never drops Out_Valid without a handshake.
//  Throughput: max 1 word per 2 clocks.
//   - Start at cycle n -> first Out_Valid at n+2.
//  Arithmetic: Address changes only by +/-1 or a wrap to the range end.
//   - Never leaves [START_ADDR..END_ADDR].
//  Checksum: 8-bit add, zero-extended word, modulo-256 wrap.
//   - Cleared on Rst and on Start accept.
// CONFIGURATION
//  CHECKSUM_EN defined: Checksum accumulates as described above.
//  CHECKSUM_EN undefined:
//   - Checksum is tied to 8'h00 and the accumulator is not built.
//   - All other behaviour is identical.
// TESTING  (ROM table 0..F = C,2,9,A,7,1,C,0,F,1,3,D,8,E,A,6)
//  1. Rst, then Start, Dir=0, Loop=0, Out_Ready=1:
//     - Out_Data sequence C,2,9,A,7,1,C,0,F,1,3,D,8,E,A,6, one word every 2 clocks.
//     - Done pulses once; Checksum=8'h7B (8'h00 without CHECKSUM_EN).
//  2. Start, Dir=1, Loop=0: Out_Addr F..0, Out_Data 6,A,E,8,...,2,C; Done after addr 0.
//  3. Out_Ready=0 for 5 clocks on word addr 3:
//     - Out_Valid stays 1, Out_Data=A, Out_Addr=3 stable.
//     - Advances to addr 4 after the handshake.
//  4. Loop=1, ascending:
//     - After addr F handshake, the next Out_Addr is 0 (Out_Data=C); Done stays 0.
//     - Stop raised at addr 5 -> addr 5 handshakes, Done pulses, no addr 6.
//  5. Rst asserted in HOLD at addr 7:
//     - Next cycle Out_Valid=0, Busy=0, Address=0, Checksum=0.
//     - Start while Busy is ignored: no restart, sequence unaffected.

Source files
------------

// File: rtl/rom_addr_sequencer_if.sv
// ---------------------------------------------------------------------------
// rom_addr_sequencer_if
// Bus bundle between the address sequencer, the lookup ROM and the
// downstream consumer of the fetched words.
//   Address    sequencer -> ROM       current ROM address
//   Rom_Data   ROM -> sequencer       combinational ROM word for Address
//   Out_Data   sequencer -> consumer  registered ROM word
//   Out_Addr   sequencer -> consumer  address that produced Out_Data
//   Out_Valid  sequencer -> consumer  Out_Data/Out_Addr valid
//   Out_Ready  consumer -> sequencer  word accepted when Out_Valid & Out_Ready
// Modports: master = sequencer side, slave = ROM/consumer side.
// ---------------------------------------------------------------------------
interface rom_addr_sequencer_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 4
);
  logic [ADDR_W-1:0] Address;
  logic [DATA_W-1:0] Rom_Data;
  logic [DATA_W-1:0] Out_Data;
  logic [ADDR_W-1:0] Out_Addr;
  logic              Out_Valid;
  logic              Out_Ready;

  modport master (
    output Address, Out_Data, Out_Addr, Out_Valid,
    input  Rom_Data, Out_Ready
  );

  modport slave (
    input  Address, Out_Data, Out_Addr, Out_Valid,
    output Rom_Data, Out_Ready
  );
endinterface

// File: rtl/rom_addr_sequencer.sv
// ---------------------------------------------------------------------------
// rom_addr_sequencer
// Walks the lookup ROM address range [START_ADDR..END_ADDR] ascending or
// descending, samples the combinational ROM word and streams each word to a
// downstream consumer over a valid/ready handshake (at most one word every
// two clocks). A run is a single pass, or a continuous wrap when Loop is set
// at Start; Stop ends a run after the word currently in flight handshakes.
// Ports:
//   Clk       rising-edge clock
//   Rst       synchronous active-high reset
//   Start     begin a run (sampled only while idle)
//   Dir       0 = ascending, 1 = descending (latched with Start)
//   Loop      1 = wrap and continue (latched with Start)
//   Stop      end the run after the current word handshakes
//   bus       ROM address/data and output stream (master modport)
//   Busy      high whenever a run is active
//   Done      one-cycle pulse when a run ends
//   Checksum  modulo-256 sum of the words accepted downstream this run
// Configuration macro: CHECKSUM_EN. When undefined, Checksum is tied to 0
// and the accumulator is not built.
// ---------------------------------------------------------------------------
module rom_addr_sequencer #(
  parameter int ADDR_W     = 4,
  parameter int DATA_W     = 4,
  parameter int START_ADDR = 0,
  parameter int END_ADDR   = 15
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 Start,
  input  logic                 Dir,
  input  logic                 Loop,
  input  logic                 Stop,
  rom_addr_sequencer_if.master bus,
  output logic                 Busy,
  output logic                 Done,
  output logic [7:0]           Checksum
);

  localparam logic [ADDR_W-1:0] ADDR_LO  = ADDR_W'(START_ADDR);
  localparam logic [ADDR_W-1:0] ADDR_HI  = ADDR_W'(END_ADDR);
  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_HOLD,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [ADDR_W-1:0] out_addr_q, out_addr_d;
  logic              out_valid_q, out_valid_d;
  logic              dir_q, dir_d;
  logic              loop_q, loop_d;
  logic              stop_q, stop_d;
`ifdef CHECKSUM_EN
  logic [7:0]        checksum_q, checksum_d;
`endif

  logic handshake;
  logic at_last;
  logic [ADDR_W-1:0] first_addr;

  // Out_Valid is only ever high in HOLD, so this is the HOLD handshake.
  assign handshake  = out_valid_q & bus.Out_Ready;
  assign at_last    = dir_q ? (addr_q == ADDR_LO) : (addr_q == ADDR_HI);
  assign first_addr = dir_q ? ADDR_HI : ADDR_LO;

  // Next-state logic. A Stop arriving in the very cycle of the handshake
  // also ends the run, so the consumer never sees one word too many.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    out_data_d  = out_data_q;
    out_addr_d  = out_addr_q;
    out_valid_d = out_valid_q;
    dir_d       = dir_q;
    loop_d      = loop_q;
    stop_d      = stop_q;
`ifdef CHECKSUM_EN
    checksum_d  = checksum_q;
`endif

    if (state_q != S_IDLE && Stop) begin
      stop_d = 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        if (Start) begin
          dir_d   = Dir;
          loop_d  = Loop;
          stop_d  = 1'b0;
          addr_d  = Dir ? ADDR_HI : ADDR_LO;
          state_d = S_FETCH;
`ifdef CHECKSUM_EN
          checksum_d = 8'h00;
`endif
        end
      end

      S_FETCH: begin
        out_data_d  = bus.Rom_Data;
        out_addr_d  = addr_q;
        out_valid_d = 1'b1;
        state_d     = S_HOLD;
      end

      S_HOLD: begin
        if (handshake) begin
          out_valid_d = 1'b0;
`ifdef CHECKSUM_EN
          checksum_d  = checksum_q + 8'(out_data_q);
`endif
          if (stop_q || Stop) begin
            state_d = S_DONE;
          end else if (at_last) begin
            if (loop_q) begin
              addr_d  = first_addr;
              state_d = S_FETCH;
            end else begin
              state_d = S_DONE;
            end
          end else begin
            addr_d  = dir_q ? (addr_q - ADDR_ONE) : (addr_q + ADDR_ONE);
            state_d = S_FETCH;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset is synchronous.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q     <= S_IDLE;
      addr_q      <= ADDR_LO;
      out_data_q  <= '0;
      out_addr_q  <= '0;
      out_valid_q <= 1'b0;
      dir_q       <= 1'b0;
      loop_q      <= 1'b0;
      stop_q      <= 1'b0;
`ifdef CHECKSUM_EN
      checksum_q  <= 8'h00;
`endif
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      out_data_q  <= out_data_d;
      out_addr_q  <= out_addr_d;
      out_valid_q <= out_valid_d;
      dir_q       <= dir_d;
      loop_q      <= loop_d;
      stop_q      <= stop_d;
`ifdef CHECKSUM_EN
      checksum_q  <= checksum_d;
`endif
    end
  end

  assign bus.Address   = addr_q;
  assign bus.Out_Data  = out_data_q;
  assign bus.Out_Addr  = out_addr_q;
  assign bus.Out_Valid = out_valid_q;
  assign Busy          = (state_q != S_IDLE);
  assign Done          = (state_q == S_DONE);

`ifdef CHECKSUM_EN
  assign Checksum = checksum_q;
`else
  assign Checksum = 8'h00;
`endif

endmodule

// File: tb/tb_rom_addr_sequencer.sv
// ---------------------------------------------------------------------------
// tb_rom_addr_sequencer
// Drives runs of the ROM address sequencer against a model of the 16x4 ROM.
// For each run the expected (address, word) stream is computed from the
// range/direction/wrap rules and queued; a monitor pops one entry per
// accepted word and compares. Run-level results (Done pulse, checksum,
// latency) and reset behaviour are checked by the stimulus tasks.
// ---------------------------------------------------------------------------
module tb_rom_addr_sequencer;

  localparam int ADDR_W     = 4;
  localparam int DATA_W     = 4;
  localparam int START_ADDR = 0;
  localparam int END_ADDR   = 15;
  localparam int RANGE_LEN  = END_ADDR - START_ADDR + 1;
  localparam int RUN_LIMIT  = 600;

  logic       Clk = 1'b0;
  logic       Rst = 1'b1;
  logic       Start = 1'b0;
  logic       Dir = 1'b0;
  logic       Loop = 1'b0;
  logic       Stop = 1'b0;
  logic       Busy;
  logic       Done;
  logic [7:0] Checksum;

  rom_addr_sequencer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  rom_addr_sequencer #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .START_ADDR(START_ADDR), .END_ADDR(END_ADDR)
  ) dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .Dir(Dir), .Loop(Loop), .Stop(Stop),
    .bus(bus.master), .Busy(Busy), .Done(Done), .Checksum(Checksum)
  );

  always #5 Clk = ~Clk;

  // Lookup ROM contents, also the reference for expected words.
  logic [3:0] romTable [16] = '{4'hC, 4'h2, 4'h9, 4'hA, 4'h7, 4'h1, 4'hC, 4'h0,
                                4'hF, 4'h1, 4'h3, 4'hD, 4'h8, 4'hE, 4'hA, 4'h6};

  always_comb bus.Rom_Data = romTable[bus.Address];

  typedef struct packed {
    logic [3:0] addr;
    logic [3:0] data;
  } word_t;

  word_t expQ[$];
  int testsRun = 0;
  int testsFailed = 0;
  int hsCount = 0;
  int doneCount = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Monitor: a word is accepted on the next rising edge whenever valid and
  // ready are both high mid-cycle.
  always @(negedge Clk) begin
    word_t w;
    if (!Rst && bus.Out_Valid && bus.Out_Ready) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected word", {24'h0, bus.Out_Addr, bus.Out_Data}, 32'hFFFF_FFFF);
      end else begin
        w = expQ.pop_front();
        checkOutput("stream addr", 32'(bus.Out_Addr), 32'(w.addr));
        checkOutput("stream data", 32'(bus.Out_Data), 32'(w.data));
      end
      hsCount++;
    end
    if (!Rst && Done) doneCount++;
  end

  // One run: queue the expected stream, start, feed randomized backpressure,
  // optional Stop before the last wanted word, optional stall, and check the
  // run-level results once Done has pulsed.
  task automatic applyStimulus(input bit dir, input bit loop, input int nWords,
                               input bit useStop, input int readyPct,
                               input int stallAddr, input bit spurious,
                               input bit checkTiming);
    int a, expSum, doneStart, hsStart, cycles, firstValid, doneCycle;
    bit stopSent, stallDone;
    logic [7:0] expChk;
    word_t w;

    expSum = 0;
    for (int i = 0; i < nWords; i++) begin
      a = dir ? (END_ADDR - (i % RANGE_LEN)) : (START_ADDR + (i % RANGE_LEN));
      w.addr = a[3:0];
      w.data = romTable[a];
      expQ.push_back(w);
      expSum += int'(romTable[a]);
    end
`ifdef CHECKSUM_EN
    expChk = 8'(expSum % 256);
`else
    expChk = 8'h00;
`endif

    doneStart  = doneCount;
    hsStart    = hsCount;
    firstValid = -1;
    doneCycle  = -1;
    stopSent   = 1'b0;
    stallDone  = 1'b0;

    Start = 1'b1; Dir = dir; Loop = loop;
    bus.Out_Ready = ($urandom_range(99) < readyPct);
    @(posedge Clk); #1;
    Start = 1'b0; Dir = 1'($urandom); Loop = 1'($urandom);
    cycles = 1;

    while (doneCount == doneStart && cycles < RUN_LIMIT) begin
      if (firstValid < 0 && bus.Out_Valid) firstValid = cycles;
      if (doneCycle < 0 && Done) doneCycle = cycles;
      Start = 1'b0;
      Stop  = 1'b0;
      if (stallAddr >= 0 && !stallDone && bus.Out_Valid && bus.Out_Addr == 4'(stallAddr)) begin
        stallDone = 1'b1;
        bus.Out_Ready = 1'b0;
        repeat (5) begin
          @(posedge Clk); #1;
          cycles++;
          checkOutput("stall valid", 32'(bus.Out_Valid), 32'd1);
          checkOutput("stall data", 32'(bus.Out_Data), 32'(romTable[stallAddr]));
          checkOutput("stall addr", 32'(bus.Out_Addr), 32'(stallAddr));
        end
        bus.Out_Ready = 1'b1;
      end else begin
        bus.Out_Ready = ($urandom_range(99) < readyPct);
        if (useStop && !stopSent && (hsCount - hsStart) == nWords - 1 && Busy) begin
          Stop = 1'b1;
          bus.Out_Ready = 1'b0;
          stopSent = 1'b1;
        end
        if (spurious && Busy && $urandom_range(3) == 0) begin
          Start = 1'b1; Dir = 1'($urandom); Loop = 1'($urandom);
        end
      end
      @(posedge Clk); #1;
      cycles++;
    end
    Start = 1'b0;
    Stop  = 1'b0;

    checkOutput("done reached", 32'(doneCount != doneStart), 32'd1);
    checkOutput("done low after pulse", 32'(Done), 32'd0);
    checkOutput("done pulse count", 32'(doneCount - doneStart), 32'd1);
    checkOutput("idle after run", 32'(Busy), 32'd0);
    checkOutput("words missing", 32'(expQ.size()), 32'd0);
    checkOutput("checksum", 32'(Checksum), 32'(expChk));
    if (checkTiming) begin
      checkOutput("first valid latency", 32'(firstValid), 32'd2);
      checkOutput("run length", 32'(doneCycle), 32'(2 * nWords + 1));
    end
    expQ.delete();
    bus.Out_Ready = 1'b1;
    repeat ($urandom_range(3)) @(posedge Clk);
    #1;
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, " valid"}, 32'(bus.Out_Valid), 32'd0);
    checkOutput({tag, " busy"}, 32'(Busy), 32'd0);
    checkOutput({tag, " done"}, 32'(Done), 32'd0);
    checkOutput({tag, " address"}, 32'(bus.Address), 32'(START_ADDR));
    checkOutput({tag, " checksum"}, 32'(Checksum), 32'd0);
    checkOutput({tag, " out_data"}, 32'(bus.Out_Data), 32'd0);
    checkOutput({tag, " out_addr"}, 32'(bus.Out_Addr), 32'd0);
  endtask

  // Ascending single pass, reset while word 7 is held; Start pulses while
  // busy must not disturb the stream seen up to that point.
  task automatic resetMidRun();
    word_t w;
    int cycles;
    for (int i = 0; i < RANGE_LEN; i++) begin
      w.addr = 4'(START_ADDR + i);
      w.data = romTable[START_ADDR + i];
      expQ.push_back(w);
    end
    bus.Out_Ready = 1'b1;
    Start = 1'b1; Dir = 1'b0; Loop = 1'b0;
    @(posedge Clk); #1;
    Start = 1'b0;
    cycles = 0;
    while (!(bus.Out_Valid && bus.Out_Addr == 4'd7) && cycles < 100) begin
      Start = Busy && (cycles % 3 == 0);
      Dir   = 1'($urandom);
      @(posedge Clk); #1;
      cycles++;
    end
    Start = 1'b0;
    checkOutput("reached addr 7", 32'(cycles < 100), 32'd1);
    bus.Out_Ready = 1'b0;
    Rst = 1'b1;
    @(posedge Clk); #1;
    checkResetState("mid-run reset");
    checkOutput("words before reset", 32'(expQ.size()), 32'(RANGE_LEN - 7));
    expQ.delete();
    Rst = 1'b0;
    @(posedge Clk); #1;
    checkOutput("stays idle", 32'(Busy), 32'd0);
    bus.Out_Ready = 1'b1;
  endtask

  initial begin
    bit rDir, rLoop, rStop;
    int rWords;
    bus.Out_Ready = 1'b1;
    Rst = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    checkResetState("reset");
    Rst = 1'b0;
    @(posedge Clk); #1;

    $display("[TB] ascending pass");
    applyStimulus(1'b0, 1'b0, RANGE_LEN, 1'b0, 100, -1, 1'b0, 1'b1);
    $display("[TB] descending pass");
    applyStimulus(1'b1, 1'b0, RANGE_LEN, 1'b0, 100, -1, 1'b0, 1'b1);
    $display("[TB] backpressure on addr 3");
    applyStimulus(1'b0, 1'b0, RANGE_LEN, 1'b0, 100, 3, 1'b0, 1'b0);
    $display("[TB] wrap then stop at addr 5");
    applyStimulus(1'b0, 1'b1, RANGE_LEN + 6, 1'b1, 100, -1, 1'b1, 1'b0);
    $display("[TB] reset mid-run");
    resetMidRun();

    $display("[TB] randomized runs");
    for (int r = 0; r < 24; r++) begin
      rDir  = 1'($urandom);
      rLoop = 1'($urandom);
      if (rLoop) begin
        rStop  = 1'b1;
        rWords = $urandom_range(40, 1);
      end else begin
        rStop  = 1'($urandom);
        rWords = rStop ? $urandom_range(RANGE_LEN, 1) : RANGE_LEN;
      end
      applyStimulus(rDir, rLoop, rWords, rStop, $urandom_range(100, 30), -1,
                    1'($urandom), 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
